// File: rtl/engine_frame_sequencer.sv
// Frame sequencer: gains an input sample, dispatches it to all pipelines, waits for
// completion, then mixes the active pipeline output (with optional crossfade) to the output.
module engine_frame_sequencer #(
    parameter int data_width     = 16,
    parameter int n_pipelines    = 2,
    parameter int gain_shift     = 5,
    parameter int timeout_cycles = 4096,
    parameter int xfade_log2     = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [data_width-1:0]               in_sample,
    input  logic                                sample_ready,
    input  logic                                set_input_gain,
    input  logic [data_width-1:0]               input_gain,
    input  logic                                swap_req,
    input  logic [$clog2(n_pipelines)-1:0]      swap_target,
    input  logic                                clear_flags,
    input  logic [n_pipelines-1:0]              pipe_ready,
    input  logic [n_pipelines*data_width-1:0]   pipe_out,
    output logic [data_width-1:0]               pipe_in_sample,
    output logic                                pipe_tick,
    output logic [data_width-1:0]               out_sample,
    output logic                                out_valid,
    output logic                                ready,
    output logic                                overrun,
    output logic                                timeout,
    output logic [$clog2(n_pipelines)-1:0]      current_pipeline,
    output logic                                swapping,
    output logic [31:0]                         sample_ctr
);
    localparam int PW = $clog2(n_pipelines);
    localparam int PRW = 2 * data_width;
    localparam int MW = data_width + xfade_log2 + 1;
    localparam int KW = xfade_log2 + 1;
    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [KW-1:0] L_LEN = KW'(1 << xfade_log2);
    localparam logic signed [PRW-1:0] SAT_MAX = {{(data_width+1){1'b0}}, {(data_width-1){1'b1}}};
    localparam logic signed [PRW-1:0] SAT_MIN = {{(data_width+1){1'b1}}, {(data_width-1){1'b0}}};

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GAIN     = 3'd1;
    localparam logic [2:0] S_DISPATCH = 3'd2;
    localparam logic [2:0] S_GUARD    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_MIX      = 3'd5;
    localparam logic [2:0] S_OUTPUT   = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [data_width-1:0] in_lat_q, in_lat_d;
    logic [data_width-1:0] gain_q, gain_d;
    logic [data_width-1:0] pin_q, pin_d;
    logic                  tick_q, tick_d;
    logic [data_width-1:0] mix_q, mix_d;
    logic [data_width-1:0] out_q, out_d;
    logic                  oval_q, oval_d;
    logic                  ready_q, ready_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
    logic [PW-1:0]         cur_q, cur_d;
    logic [PW-1:0]         target_q, target_d;
    logic                  swapping_q, swapping_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic [31:0]           ctr_q, ctr_d;

    // Gain datapath: full-width signed product, arithmetic shift, clamp to sample range.
    logic signed [PRW-1:0] in_x, gain_x, prod, prod_sh;
    logic [data_width-1:0] gained;
    assign in_x    = {{data_width{in_lat_q[data_width-1]}}, in_lat_q};
    assign gain_x  = {{data_width{gain_q[data_width-1]}}, gain_q};
    assign prod    = in_x * gain_x;
    assign prod_sh = prod >>> gain_shift;
    assign gained  = (prod_sh > SAT_MAX) ? SAT_MAX[data_width-1:0] :
                     (prod_sh < SAT_MIN) ? SAT_MIN[data_width-1:0] : prod_sh[data_width-1:0];

    // Crossfade: weights (L-k) and k always sum to L, so the shifted result fits a sample.
    logic [data_width-1:0] a_smp, b_smp, xfade;
    logic signed [MW-1:0]  a_x, b_x, wa, wb, mix_sum, mix_sh;
    assign a_smp   = pipe_out[int'(cur_q)*data_width +: data_width];
    assign b_smp   = pipe_out[int'(target_q)*data_width +: data_width];
    assign a_x     = {{(MW-data_width){a_smp[data_width-1]}}, a_smp};
    assign b_x     = {{(MW-data_width){b_smp[data_width-1]}}, b_smp};
    assign wa      = {{(MW-KW){1'b0}}, L_LEN - k_q};
    assign wb      = {{(MW-KW){1'b0}}, k_q};
    assign mix_sum = a_x * wa + b_x * wb;
    assign mix_sh  = mix_sum >>> xfade_log2;
    assign xfade   = mix_sh[data_width-1:0];

    always_comb begin
        state_d    = state_q;
        in_lat_d   = in_lat_q;
        gain_d     = gain_q;
        pin_d      = pin_q;
        tick_d     = 1'b0;
        mix_d      = mix_q;
        out_d      = out_q;
        oval_d     = 1'b0;
        ready_d    = ready_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        cur_d      = cur_q;
        target_d   = target_q;
        swapping_d = swapping_q;
        k_d        = k_q;
        wcnt_d     = wcnt_q;
        ctr_d      = ctr_q;

        if (set_input_gain) gain_d = input_gain;
        // Clears come first so a same-cycle error event below re-sets the flag.
        if (clear_flags) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (sample_ready && state_q != S_IDLE) overrun_d = 1'b1;
        if (swap_req && !swapping_q && swap_target != cur_q && int'(swap_target) < n_pipelines) begin
            swapping_d = 1'b1;
            target_d   = swap_target;
            k_d        = '0;
        end

        case (state_q)
            S_IDLE: if (sample_ready) begin
                in_lat_d = in_sample;
                ctr_d    = ctr_q + 32'd1;
                ready_d  = 1'b0;
                state_d  = S_GAIN;
            end
            S_GAIN: begin
                pin_d   = gained;
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                tick_d  = 1'b1;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (&pipe_ready) begin
                    state_d = S_MIX;
                end else if (wcnt_q == CW'(timeout_cycles - 1)) begin
                    timeout_d = 1'b1;
                    oval_d    = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            S_MIX: begin
                if (swapping_q) begin
                    mix_d = xfade;
                    if (k_q == L_LEN - KW'(1)) begin
                        cur_d      = target_q;
                        swapping_d = 1'b0;
                        k_d        = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    mix_d = a_smp;
                end
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_d   = mix_q;
                oval_d  = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_lat_q   <= '0;
            gain_q     <= data_width'(1 << gain_shift);
            pin_q      <= '0;
            tick_q     <= 1'b0;
            mix_q      <= '0;
            out_q      <= '0;
            oval_q     <= 1'b0;
            ready_q    <= 1'b1;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cur_q      <= '0;
            target_q   <= '0;
            swapping_q <= 1'b0;
            k_q        <= '0;
            wcnt_q     <= '0;
            ctr_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_lat_q   <= in_lat_d;
            gain_q     <= gain_d;
            pin_q      <= pin_d;
            tick_q     <= tick_d;
            mix_q      <= mix_d;
            out_q      <= out_d;
            oval_q     <= oval_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            cur_q      <= cur_d;
            target_q   <= target_d;
            swapping_q <= swapping_d;
            k_q        <= k_d;
            wcnt_q     <= wcnt_d;
            ctr_q      <= ctr_d;
        end
    end

    assign pipe_in_sample   = pin_q;
    assign pipe_tick        = tick_q;
    assign out_sample       = out_q;
    assign out_valid        = oval_q;
    assign ready            = ready_q;
    assign overrun          = overrun_q;
    assign timeout          = timeout_q;
    assign current_pipeline = cur_q;
    assign swapping         = swapping_q;
    assign sample_ctr       = ctr_q;
endmodule
